hdmi_tmds_encoder: RTL and testbench
====================================

Name: hdmi_tmds_encoder

Overview:
- Single-channel TMDS encoder for the HDMI transmit path. It succeeds the DVI-only tmds_encoder by adding TERC4 data-island encoding and video/data-island guard bands.
- A CHANNEL parameter selects the per-lane guard-band pattern.
- The transmit top instantiates it three times (CHANNEL 0,1,2). Each output feeds the 10:1 serialiser.
- Fixed 2-cycle latency from input to tmds in every mode.

Parameters:
- CHANNEL, 0, lane index 0..2. Selects guard-band patterns. Any other value is an elaboration error.

Ports:
- clk  input  1  pixel clock
- rst  input  1  reset
- mode  input  3  tmds_mode_t: 0 CTRL, 1 VIDEO, 2 VIDEO_GB, 3 ISLAND, 4 ISLAND_GB
- data  input  8  pixel component, used in VIDEO
- ctrl  input  2  control bits {c1,c0}; on lane 0 this is {vsync,hsync}
- aux  input  4  TERC4 nibble, used in ISLAND
- tmds  output  10  encoded symbol, bit 0 transmitted first
- disparity  output  6  signed running disparity, for debug/verification

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk. All registers clear on rst assertion, independent of clk.
- Reset values: tmds = 10'b1101010100 (CTRL token 00); disparity = 0; all pipeline registers = CTRL/zero.
- Stage 1 (registered):
  - Captures mode, ctrl and aux.
  - Computes q_m[8:0] from data.
  - Uses XNOR if popcount(data) > 4, or popcount(data) == 4 and data[0] == 0. Otherwise uses XOR.
  - q_m[0] = data[0]; q_m[i] = q_m[i-1] op data[i]; q_m[8] = 1 for XOR, 0 for XNOR.
  - Registers n1 = popcount(q_m[7:0]) (4 bits).
- Stage 2 (registered): produces tmds and updates cnt (6-bit signed, exported as disparity). n0 = 8 - n1.
- Stage 2, VIDEO mode:
  - If cnt == 0 or n1 == n0:
    - tmds = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - If q_m[8]: cnt += n1 - n0. Else: cnt += n0 - n1.
  - Else if (cnt > 0 and n1 > n0) or (cnt < 0 and n0 > n1):
    - tmds = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (n0 - n1).
  - Else:
    - tmds = {0, q_m[8], q_m[7:0]}.
    - cnt += (n1 - n0) - 2*(~q_m[8]).
  - All arithmetic is sign-extended to 6 bits. cnt must never wrap.
- Stage 2, all other modes: cnt <= 0 on that cycle. A new video period therefore always starts from disparity 0.
- CTRL:
  - 00 -> 1101010100
  - 01 -> 0010101011
  - 10 -> 0101010100
  - 11 -> 1010101011
- ISLAND: tmds = TERC4[aux].
- ISLAND_GB:
  - CHANNEL 0: TERC4[{2'b11, ctrl}].
  - CHANNEL 1, 2: 0100110011.
- VIDEO_GB:
  - CHANNEL 0, 2: 1011001100.
  - CHANNEL 1: 0100110011.
- Mode codes 5..7 encode as CTRL.
- Mode switches take effect per cycle with no bubbles. Output reflects the inputs of cycle N at cycle N+2.
- Reset mid-stream: both stages flush to reset values immediately. The first post-reset output reflects inputs sampled in the first edge after rst falls, two edges later.

Decomposition:
- Package hdmi_pkg holds:
  - tmds_mode_t enum.
  - CTRL_TOKEN[4] constant array.
  - TERC4[16] constant array, values 0..15:
    - 0-3: 1010011100, 1001100011, 1011100100, 1011100010
    - 4-7: 0101110001, 0100011110, 0110001110, 0100111100
    - 8-11: 1011001100, 0100111001, 0110011100, 1011000111
    - 12-15: 1010001110, 1001110001, 0101100011, 1011000011
  - VGB_A = 1011001100, VGB_B = 0100110011.
- One sub-module, tmds_qm_stage: combinational q_m/n1 computation, instantiated in stage 1. It is reused by the bench reference model.

Test Plan:
- Reset with mode=CTRL, ctrl=00 held -> tmds = 1101010100 and disparity = 0 during and after reset. Sweep ctrl 00..11 -> the four CTRL tokens appear 2 cycles later.
- VIDEO, data = 0x00 three consecutive cycles from cnt = 0 -> tmds = 0100000000, 1111111111, 0100000000; disparity = -8, 2, -6.
- ISLAND with aux = 0..15 on consecutive cycles -> the 16 TERC4 codes in order. Disparity is held at 0 throughout.
- Guard bands, per CHANNEL 0/1/2:
  - VIDEO_GB -> 1011001100 / 0100110011 / 1011001100.
  - ISLAND_GB with ctrl = 01 on CHANNEL 0 -> TERC4[13] = 1001110001. CHANNEL 1/2 -> 0100110011.
- VIDEO sweep of data 0x00..0xFF, then random data (10k cycles), checked against the reference model:
  - Outputs match bit-exactly.
  - disparity is always even and never wraps.
  - Inserting one CTRL cycle forces disparity to 0 on its output cycle.
- Assert rst for 1 cycle mid-VIDEO with cnt ≠ 0 -> tmds = 1101010100 and disparity = 0 immediately. After rst falls, data 0x00 in VIDEO encodes to 0100000000 (cnt = 0 path).

Source files
------------

// File: rtl/hdmi_pkg.sv
// Shared TMDS definitions: mode codes, control tokens, TERC4 table, guard bands.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package hdmi_pkg;

   typedef enum logic [2:0] {
      MODE_CTRL      = 3'd0,
      MODE_VIDEO     = 3'd1,
      MODE_VIDEO_GB  = 3'd2,
      MODE_ISLAND    = 3'd3,
      MODE_ISLAND_GB = 3'd4
   } tmds_mode_t;

   // Indexed by {c1,c0}
   localparam logic [9:0] CTRL_TOKEN [4] = '{
      10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
   };

   // Indexed by the 4-bit data-island nibble
   localparam logic [9:0] TERC4 [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000111,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
   };

   localparam logic [9:0] VGB_A = 10'b1011001100;
   localparam logic [9:0] VGB_B = 10'b0100110011;

endpackage

// File: rtl/tmds_qm_stage.sv
// Transition-minimising first step of TMDS video coding: q_m and its ones count.
// Latency: purely combinational.
// Backpressure: none.
module tmds_qm_stage (
   input  logic [7:0] data,
   output logic [8:0] q_m,
   output logic [3:0] n1
);

   logic [3:0] ones;
   logic       use_xnor;

   // Pick XOR/XNOR chaining from the input weight, then build q_m and count its ones
   always_comb begin
      ones = '0;
      for (int i = 0; i < 8; i++) ones = ones + {3'b000, data[i]};
      use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !data[0]);
      q_m    = '0;
      q_m[0] = data[0];
      for (int i = 1; i < 8; i++)
         q_m[i] = use_xnor ? ~(q_m[i-1] ^ data[i]) : (q_m[i-1] ^ data[i]);
      q_m[8] = ~use_xnor;
      n1 = '0;
      for (int i = 0; i < 8; i++) n1 = n1 + {3'b000, q_m[i]};
   end

endmodule

// File: rtl/hdmi_tmds_encoder.sv
// Single-lane HDMI TMDS encoder: video (DC balanced), control, TERC4 islands, guard bands.
// Latency: fixed 2 cycles from inputs to tmds in every mode.
// Backpressure: none; one symbol is accepted and produced every clk.
module hdmi_tmds_encoder
   import hdmi_pkg::*;
#(
   parameter int CHANNEL = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        mode,
   input  logic [7:0]        data,
   input  logic [1:0]        ctrl,
   input  logic [3:0]        aux,
   output logic [9:0]        tmds,
   output logic signed [5:0] disparity
);

   if (CHANNEL < 0 || CHANNEL > 2) begin : g_bad_channel
      $error("hdmi_tmds_encoder: CHANNEL must be 0, 1 or 2");
   end

   logic [8:0]        qm_c;
   logic [3:0]        n1_c;
   logic [2:0]        s1_mode;
   logic [1:0]        s1_ctrl;
   logic [3:0]        s1_aux;
   logic [8:0]        s1_qm;
   logic [3:0]        s1_n1;
   logic signed [5:0] cnt;
   logic signed [5:0] cnt_nxt;
   logic signed [5:0] diff;
   logic [9:0]        tmds_nxt;

   tmds_qm_stage u_qm (
      .data (data),
      .q_m  (qm_c),
      .n1   (n1_c)
   );

   // Stage 1: capture the mode/side-band inputs alongside the q_m result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_mode <= MODE_CTRL;
         s1_ctrl <= '0;
         s1_aux  <= '0;
         s1_qm   <= '0;
         s1_n1   <= '0;
      end else begin
         s1_mode <= mode;
         s1_ctrl <= ctrl;
         s1_aux  <= aux;
         s1_qm   <= qm_c;
         s1_n1   <= n1_c;
      end
   end

   // n1 - n0 with n0 = 8 - n1, kept signed so the running count never mixes signedness
   assign diff = signed'({2'b00, s1_n1}) + signed'({2'b00, s1_n1}) - 6'sd8;

   // Stage 2 symbol selection; anything other than video parks the running count at zero
   always_comb begin
      tmds_nxt = CTRL_TOKEN[s1_ctrl];
      cnt_nxt  = 6'sd0;
      case (s1_mode)
         MODE_VIDEO: begin
            if ((cnt == 6'sd0) || (s1_n1 == 4'd4)) begin
               tmds_nxt = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
               cnt_nxt  = s1_qm[8] ? (cnt + diff) : (cnt - diff);
            end else if (((cnt > 6'sd0) && (s1_n1 > 4'd4)) ||
                         ((cnt < 6'sd0) && (s1_n1 < 4'd4))) begin
               tmds_nxt = {1'b1, s1_qm[8], ~s1_qm[7:0]};
               cnt_nxt  = cnt + (s1_qm[8] ? 6'sd2 : 6'sd0) - diff;
            end else begin
               tmds_nxt = {1'b0, s1_qm[8], s1_qm[7:0]};
               cnt_nxt  = cnt + diff - (s1_qm[8] ? 6'sd0 : 6'sd2);
            end
         end
         MODE_VIDEO_GB:  tmds_nxt = (CHANNEL == 1) ? VGB_B : VGB_A;
         MODE_ISLAND:    tmds_nxt = TERC4[s1_aux];
         MODE_ISLAND_GB: tmds_nxt = (CHANNEL == 0) ? TERC4[{2'b11, s1_ctrl}] : VGB_B;
         default: ;
      endcase
   end

   // Stage 2 register: output symbol and running disparity
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmds <= CTRL_TOKEN[0];
         cnt  <= 6'sd0;
      end else begin
         tmds <= tmds_nxt;
         cnt  <= cnt_nxt;
      end
   end

   assign disparity = cnt;

endmodule

// File: tb/tb_hdmi_tmds_encoder.sv
// Scoreboard bench for hdmi_tmds_encoder on all three lanes driven in parallel.
// Latency: expects every issued input back 2 cycles later.
// Backpressure: none; one input issued per cycle when active.
module tb_hdmi_tmds_encoder;

   localparam logic [2:0] M_CTRL = 3'd0, M_VIDEO = 3'd1, M_VGB = 3'd2,
                          M_ISL = 3'd3, M_IGB = 3'd4;

   typedef struct {
      logic [9:0] t0, t1, t2;
      int         d;
   } exp_t;

   logic              clk;
   logic              rst;
   logic [2:0]        mode;
   logic [7:0]        data;
   logic [1:0]        ctrl;
   logic [3:0]        aux;
   logic [9:0]        tmds0, tmds1, tmds2;
   logic signed [5:0] disp0, disp1, disp2;
   logic [7:0]        qm_in;
   logic [8:0]        qm_out;
   logic [3:0]        n1_out;

   logic issued, iss_d1, iss_d2;
   exp_t sb[$];
   int   model_cnt;
   int   n_checks, n_fail;

   hdmi_tmds_encoder #(.CHANNEL(0)) dut0 (.clk(clk), .rst(rst), .mode(mode), .data(data),
      .ctrl(ctrl), .aux(aux), .tmds(tmds0), .disparity(disp0));
   hdmi_tmds_encoder #(.CHANNEL(1)) dut1 (.clk(clk), .rst(rst), .mode(mode), .data(data),
      .ctrl(ctrl), .aux(aux), .tmds(tmds1), .disparity(disp1));
   hdmi_tmds_encoder #(.CHANNEL(2)) dut2 (.clk(clk), .rst(rst), .mode(mode), .data(data),
      .ctrl(ctrl), .aux(aux), .tmds(tmds2), .disparity(disp2));

   tmds_qm_stage u_qm_ref (.data(qm_in), .q_m(qm_out), .n1(n1_out));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference tables and model ----------------
   function automatic logic [9:0] ctrl_ref(input logic [1:0] c);
      case (c)
         2'd0: return 10'b1101010100;
         2'd1: return 10'b0010101011;
         2'd2: return 10'b0101010100;
         default: return 10'b1010101011;
      endcase
   endfunction

   function automatic logic [9:0] terc4_ref(input int i);
      case (i)
         0: return 10'b1010011100;   1: return 10'b1001100011;
         2: return 10'b1011100100;   3: return 10'b1011100010;
         4: return 10'b0101110001;   5: return 10'b0100011110;
         6: return 10'b0110001110;   7: return 10'b0100111100;
         8: return 10'b1011001100;   9: return 10'b0100111001;
         10: return 10'b0110011100;  11: return 10'b1011000111;
         12: return 10'b1010001110;  13: return 10'b1001110001;
         14: return 10'b0101100011;  default: return 10'b1011000011;
      endcase
   endfunction

   // q_m bit i is the parity of data[i:0]; the XNOR chain additionally inverts odd bits
   function automatic logic [8:0] ref_qm(input logic [7:0] d);
      int         ones = $countones(d);
      bit         xn   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      logic [8:0] r;
      bit         p    = 1'b0;
      for (int i = 0; i < 8; i++) begin
         p    = p ^ d[i];
         r[i] = p ^ (xn && (i % 2 == 1));
      end
      r[8] = !xn;
      return r;
   endfunction

   function automatic exp_t model(input logic [2:0] m, input logic [7:0] d,
                                  input logic [1:0] c, input logic [3:0] a);
      exp_t       e;
      logic [8:0] qm;
      logic [9:0] sym;
      int         n1, n0;
      sym = ctrl_ref(c);
      e.t0 = sym; e.t1 = sym; e.t2 = sym; e.d = 0;
      if (m == M_VIDEO) begin
         qm = ref_qm(d);
         n1 = $countones(qm[7:0]);
         n0 = 8 - n1;
         if (model_cnt == 0 || n1 == n0) begin
            sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            model_cnt += qm[8] ? (n1 - n0) : (n0 - n1);
         end else if ((model_cnt > 0 && n1 > n0) || (model_cnt < 0 && n0 > n1)) begin
            sym = {1'b1, qm[8], ~qm[7:0]};
            model_cnt += (qm[8] ? 2 : 0) + (n0 - n1);
         end else begin
            sym = {1'b0, qm[8], qm[7:0]};
            model_cnt += (n1 - n0) - (qm[8] ? 0 : 2);
         end
         e.t0 = sym; e.t1 = sym; e.t2 = sym; e.d = model_cnt;
      end else begin
         model_cnt = 0;
         if (m == M_ISL) begin
            e.t0 = terc4_ref(int'(a)); e.t1 = e.t0; e.t2 = e.t0;
         end else if (m == M_VGB) begin
            e.t0 = 10'b1011001100; e.t1 = 10'b0100110011; e.t2 = 10'b1011001100;
         end else if (m == M_IGB) begin
            e.t0 = terc4_ref(12 + int'(c)); e.t1 = 10'b0100110011; e.t2 = 10'b0100110011;
         end
      end
      return e;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   // Marks which sampled input cycles carry a scoreboard entry
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         iss_d1 <= 1'b0;
         iss_d2 <= 1'b0;
      end else begin
         iss_d1 <= issued;
         iss_d2 <= iss_d1;
      end
   end

   // Monitor: pops one expectation per issued cycle once it reaches the output
   always @(negedge clk) begin
      exp_t e;
      if (iss_d2 && !rst) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("tmds_ch0", int'(tmds0), int'(e.t0));
            chk("tmds_ch1", int'(tmds1), int'(e.t1));
            chk("tmds_ch2", int'(tmds2), int'(e.t2));
            chk("disp_ch0", int'(disp0), e.d);
            chk("disp_ch1", int'(disp1), e.d);
            chk("disp_ch2", int'(disp2), e.d);
            chk("disp_even", int'(disp0[0]), 0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic [2:0] m, input logic [7:0] d,
                        input logic [1:0] c, input logic [3:0] a);
      @(posedge clk); #1;
      mode = m; data = d; ctrl = c; aux = a;
   endtask

   task automatic send(input logic [2:0] m, input logic [7:0] d,
                       input logic [1:0] c, input logic [3:0] a);
      drive(m, d, c, a);
      issued = 1'b1;
      sb.push_back(model(m, d, c, a));
   endtask

   task automatic send_fixed(input logic [2:0] m, input logic [7:0] d, input logic [1:0] c,
                             input logic [3:0] a, input logic [9:0] t0, input logic [9:0] t1,
                             input logic [9:0] t2, input int dd);
      exp_t e;
      drive(m, d, c, a);
      issued = 1'b1;
      e = model(m, d, c, a);
      e.t0 = t0; e.t1 = t1; e.t2 = t2; e.d = dd;
      sb.push_back(e);
   endtask

   task automatic idle();
      exp_t e;
      drive(M_CTRL, 8'h00, 2'b00, 4'h0);
      issued = 1'b0;
      e = model(M_CTRL, 8'h00, 2'b00, 4'h0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_tmds0"}, int'(tmds0), int'(10'b1101010100));
      chk({tag, "_tmds1"}, int'(tmds1), int'(10'b1101010100));
      chk({tag, "_tmds2"}, int'(tmds2), int'(10'b1101010100));
      chk({tag, "_disp"}, int'(disp0), 0);
   endtask

   task automatic mid_reset();
      @(posedge clk); #1;
      chk("pre_rst_disp_nonzero", int'(disp0 != 6'sd0), 1);
      rst = 1'b1; issued = 1'b0;
      mode = M_CTRL; ctrl = 2'b00; data = 8'h00; aux = 4'h0;
      sb.delete();
      model_cnt = 0;
      #2;
      check_reset_outputs("midrst_now");
      @(posedge clk); #1;
      check_reset_outputs("midrst_hold");
      rst = 1'b0;
   endtask

   initial begin
      int r;
      n_checks = 0; n_fail = 0; model_cnt = 0;
      rst = 1'b1; issued = 1'b0;
      mode = M_CTRL; data = 8'h00; ctrl = 2'b00; aux = 4'h0; qm_in = 8'h00;

      // Standalone q_m stage against the parity formulation, during reset
      for (int i = 0; i < 256; i++) begin
         qm_in = 8'(i);
         #1;
         chk("qm_value", int'(qm_out), int'(ref_qm(qm_in)));
         chk("qm_n1", int'(n1_out), $countones(ref_qm(qm_in) & 9'h0FF));
      end
      check_reset_outputs("rst_during");
      @(posedge clk); #1;
      rst = 1'b0;

      // Control tokens after reset
      for (int c = 0; c < 4; c++) send(M_CTRL, 8'h00, 2'(c), 4'h0);
      send(M_CTRL, 8'h00, 2'b00, 4'h0);

      // Zero data from a balanced start
      send_fixed(M_VIDEO, 8'h00, 2'b00, 4'h0, 10'b0100000000, 10'b0100000000, 10'b0100000000, -8);
      send_fixed(M_VIDEO, 8'h00, 2'b00, 4'h0, 10'b1111111111, 10'b1111111111, 10'b1111111111, 2);
      send_fixed(M_VIDEO, 8'h00, 2'b00, 4'h0, 10'b0100000000, 10'b0100000000, 10'b0100000000, -6);

      // Data island nibbles in order
      for (int a = 0; a < 16; a++) send(M_ISL, 8'h00, 2'b00, 4'(a));

      // Guard bands per lane
      send_fixed(M_VGB, 8'h00, 2'b00, 4'h0, 10'b1011001100, 10'b0100110011, 10'b1011001100, 0);
      send_fixed(M_IGB, 8'h00, 2'b01, 4'h0, 10'b1001110001, 10'b0100110011, 10'b0100110011, 0);
      for (int c = 0; c < 4; c++) send(M_IGB, 8'h00, 2'(c), 4'h0);

      // Full data sweep, then a single control cycle
      for (int d = 0; d < 256; d++) send(M_VIDEO, 8'(d), 2'b00, 4'h0);
      send(M_CTRL, 8'h00, 2'b11, 4'h0);

      // Randomised traffic, mostly video with occasional mode changes
      for (int i = 0; i < 10000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 80)      send(M_VIDEO, 8'($urandom), 2'($urandom), 4'($urandom));
         else if (r < 85) send(M_CTRL, 8'($urandom), 2'($urandom), 4'($urandom));
         else if (r < 90) send(M_ISL, 8'($urandom), 2'($urandom), 4'($urandom));
         else if (r < 93) send(M_VGB, 8'($urandom), 2'($urandom), 4'($urandom));
         else if (r < 96) send(M_IGB, 8'($urandom), 2'($urandom), 4'($urandom));
         else             send(3'($urandom_range(5, 7)), 8'($urandom), 2'($urandom), 4'($urandom));
      end

      // Reset in the middle of a video run
      send(M_CTRL, 8'h00, 2'b00, 4'h0);
      for (int i = 0; i < 3; i++) send(M_VIDEO, 8'h00, 2'b00, 4'h0);
      mid_reset();
      send_fixed(M_VIDEO, 8'h00, 2'b00, 4'h0, 10'b0100000000, 10'b0100000000, 10'b0100000000, -8);

      for (int i = 0; i < 4; i++) idle();
      chk("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
